// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory and buffers returned words with their PC in a 2-entry
// circular queue that is drained by decode through a valid/ready handshake.
module fetch_unit #(
   parameter int N = 8,
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   input  logic         instr_ready,
   output logic         imem_en,
   output logic [N-1:0] imem_addr,
   input  logic [W-1:0] imem_rdata,
   output logic         instr_valid,
   output logic [W-1:0] instr,
   output logic [N-1:0] instr_pc,
   output logic [N-1:0] instr_pc4,
   output logic         busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] fetch_pc_q, fetch_pc_d;
   logic [N-1:0] addr_q, addr_d;        // last issued address, held while idle
   logic [N-1:0] req_pc_q, req_pc_d;    // PC of the request currently in flight
   logic         inflight_q, inflight_d;
   logic [1:0]   count_q, count_d;
   logic         head_q, head_d;

   // Queue storage; pc4 is stored rather than derived so it reads 0 after reset.
   logic [W-1:0] ent_instr_q [2];
   logic [W-1:0] ent_instr_d [2];
   logic [N-1:0] ent_pc_q    [2];
   logic [N-1:0] ent_pc_d    [2];
   logic [N-1:0] ent_pc4_q   [2];
   logic [N-1:0] ent_pc4_d   [2];

   logic       running;
   logic       redirect;
   logic       pop;
   logic       push;
   logic       issue;
   logic       tail;
   logic [2:0] occupancy;

   // Handshake and issue decisions for the current cycle.
   always_comb begin
      running   = (state_q == RUN);
      redirect  = running && branch_taken;
      pop       = (count_q != 2'd0) && instr_ready;
      push      = inflight_q && !branch_taken;
      occupancy = {1'b0, count_q} + {2'b00, inflight_q};
      // A slot is free now, or one is being freed by this cycle's pop.
      issue     = running && !branch_taken &&
                  ((occupancy < 3'd2) || ((occupancy == 3'd2) && pop));
      tail      = head_q ^ count_q[0];
   end

   // Next-state for the FSM, PC, request tracking and queue bookkeeping.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      req_pc_d   = req_pc_q;
      inflight_d = issue;
      count_d    = count_q;
      head_d     = head_q;

      if ((state_q == IDLE) && start) begin
         state_d = RUN;
      end

      if (redirect) begin
         fetch_pc_d = branch_target & ~N'(3);
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + N'(4);
      end

      if (issue) begin
         addr_d   = fetch_pc_q;
         req_pc_d = fetch_pc_q;
      end

      if (redirect) begin
         count_d = 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
         // The head stays put when the queue drains, so the payload outputs
         // keep showing the last delivered entry and tail == head again.
         if (pop && !((count_q == 2'd1) && !push)) begin
            head_d = ~head_q;
         end
      end
   end

   // Queue entry writes: a returning response lands at the tail slot.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         ent_instr_d[i] = ent_instr_q[i];
         ent_pc_d[i]    = ent_pc_q[i];
         ent_pc4_d[i]   = ent_pc4_q[i];
         if (push && (tail == 1'(i))) begin
            ent_instr_d[i] = imem_rdata;
            ent_pc_d[i]    = req_pc_q;
            ent_pc4_d[i]   = req_pc_q + N'(4);
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= '0;
         addr_q     <= '0;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         head_q     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            ent_instr_q[i] <= '0;
            ent_pc_q[i]    <= '0;
            ent_pc4_q[i]   <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         head_q     <= head_d;
         for (int i = 0; i < 2; i++) begin
            ent_instr_q[i] <= ent_instr_d[i];
            ent_pc_q[i]    <= ent_pc_d[i];
            ent_pc4_q[i]   <= ent_pc4_d[i];
         end
      end
   end

   // Outputs: memory request and queue head.
   always_comb begin
      imem_en     = issue;
      imem_addr   = issue ? fetch_pc_q : addr_q;
      instr_valid = (count_q != 2'd0);
      instr       = ent_instr_q[head_q];
      instr_pc    = ent_pc_q[head_q];
      instr_pc4   = ent_pc4_q[head_q];
      busy        = running;
   end

   // Issue throttling must keep queued plus outstanding work within capacity.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) occupancy <= 3'd2);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model tracks
// the fetch stream and is compared with the DUT every cycle, with a few
// directed scenarios pinned by literal expectations.
module tb_fetch_unit;

   logic        clk;
   logic        rst, start, br, rdy;
   logic [7:0]  tgt;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [7:0]  instr_pc, instr_pc4;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .branch_taken (br),
      .branch_target(tgt),
      .instr_ready  (rdy),
      .imem_en      (imem_en),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .instr_pc4    (instr_pc4),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [7:0] a);
      return 32'hE000_0000 + {26'd0, a[7:2]};
   endfunction

   // Synchronous instruction memory, one cycle read latency.
   initial imem_rdata = '0;
   always @(posedge clk) begin
      if (imem_en === 1'b1) imem_rdata <= mem_word(imem_addr);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_imem_en"},     {31'd0, imem_en},     32'd0);
      chk({tag, "_imem_addr"},   {24'd0, imem_addr},   32'd0);
      chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_instr"},       instr,                32'd0);
      chk({tag, "_instr_pc"},    {24'd0, instr_pc},    32'd0);
      chk({tag, "_instr_pc4"},   {24'd0, instr_pc4},   32'd0);
      chk({tag, "_busy"},        {31'd0, busy},        32'd0);
   endtask

   // Reference model: queue of buffered PCs, one outstanding request, and
   // the architectural stream PC that decode should see next.
   logic       m_busy;
   logic [7:0] m_fetch_pc, m_last_addr, m_infl_pc, m_stream;
   logic       m_infl;
   logic [7:0] m_q[$];

   always @(negedge clk) begin : cmp
      logic       pop, issue;
      logic [2:0] occ;
      logic [7:0] hpc;
      if (rst !== 1'b0) begin
         m_busy = 1'b0; m_fetch_pc = 8'd0; m_last_addr = 8'd0;
         m_infl = 1'b0; m_infl_pc = 8'd0; m_stream = 8'd0;
         m_q.delete();
      end else begin
         pop   = (m_q.size() != 0) && rdy;
         occ   = 3'(m_q.size()) + {2'b00, m_infl};
         issue = m_busy && !br && ((occ < 3'd2) || ((occ == 3'd2) && pop));

         chk("busy",        {31'd0, busy},        {31'd0, m_busy});
         chk("imem_en",     {31'd0, imem_en},     {31'd0, issue});
         chk("imem_addr",   {24'd0, imem_addr},   {24'd0, issue ? m_fetch_pc : m_last_addr});
         chk("instr_valid", {31'd0, instr_valid}, {31'd0, (m_q.size() != 0)});
         if (m_q.size() != 0) begin
            hpc = m_q[0];
            chk("instr_pc",  {24'd0, instr_pc},  {24'd0, hpc});
            chk("instr_pc4", {24'd0, instr_pc4}, {24'd0, hpc + 8'd4});
            chk("instr",     instr,              mem_word(hpc));
         end
         if (pop) begin
            chk("stream_pc", {24'd0, instr_pc}, {24'd0, m_stream});
            m_stream = m_stream + 8'd4;
         end

         if (m_busy && br) begin
            m_q.delete();
            m_infl     = 1'b0;
            m_fetch_pc = tgt & 8'hFC;
            m_stream   = tgt & 8'hFC;
         end else begin
            if (pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_pc);
            m_infl = issue;
            if (issue) begin
               m_infl_pc   = m_fetch_pc;
               m_last_addr = m_fetch_pc;
               m_fetch_pc  = m_fetch_pc + 8'd4;
            end
         end
         if (!m_busy && start) begin
            m_busy   = 1'b1;
            m_stream = 8'd0;
         end
      end
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      rst = 1'b1; start = 1'b0; br = 1'b0; tgt = 8'd0; rdy = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check_zero("reset");

      // Start at cycle 0, first instruction at cycle 3.
      step(); start = 1'b1; rdy = 1'b1;
      step(); start = 1'b0;
      @(negedge clk);
      chk("c1_busy", {31'd0, busy}, 32'd1);
      chk("c1_en",   {31'd0, imem_en}, 32'd1);
      chk("c1_addr", {24'd0, imem_addr}, 32'd0);
      step();
      @(negedge clk);
      chk("c2_valid", {31'd0, instr_valid}, 32'd0);
      step();
      @(negedge clk);
      chk("c3_valid", {31'd0, instr_valid}, 32'd1);
      chk("c3_instr", instr, 32'hE000_0000);
      chk("c3_pc",    {24'd0, instr_pc}, 32'd0);
      chk("c3_pc4",   {24'd0, instr_pc4}, 32'd4);
      repeat (5) step();
      @(negedge clk);
      chk("c8_pc",    {24'd0, instr_pc}, 32'h14);
      chk("c8_instr", instr, 32'hE000_0005);

      // Backpressure for 4 cycles.
      step(); rdy = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("bp_en",  {31'd0, imem_en}, 32'd0);
      chk("bp_pc",  {24'd0, instr_pc}, 32'h18);
      step(); rdy = 1'b1;
      @(negedge clk);
      chk("bp_resume_en",   {31'd0, imem_en}, 32'd1);
      chk("bp_resume_addr", {24'd0, imem_addr}, 32'h20);

      // Branch while the queue is full.
      step(); rdy = 1'b0;
      step(); step();
      step(); br = 1'b1; tgt = 8'h40;
      @(negedge clk);
      chk("br_t_en", {31'd0, imem_en}, 32'd0);
      step(); br = 1'b0; rdy = 1'b1;
      @(negedge clk);
      chk("br_t1_addr",  {24'd0, imem_addr}, 32'h40);
      chk("br_t1_valid", {31'd0, instr_valid}, 32'd0);
      step();
      @(negedge clk);
      chk("br_t2_valid", {31'd0, instr_valid}, 32'd0);
      step();
      @(negedge clk);
      chk("br_t3_pc", {24'd0, instr_pc}, 32'h40);

      // Branch coinciding with a pop and a push in steady state.
      repeat (3) step();
      br = 1'b1; tgt = 8'h80;
      step(); br = 1'b0;
      @(negedge clk);
      chk("brpp_t1_valid", {31'd0, instr_valid}, 32'd0);
      step(); step();
      @(negedge clk);
      chk("brpp_t3_pc", {24'd0, instr_pc}, 32'h80);

      // Address wrap.
      step(); br = 1'b1; tgt = 8'hF8;
      step(); br = 1'b0;
      step(); step();
      @(negedge clk);
      chk("wrap_pc_f8", {24'd0, instr_pc}, 32'hF8);
      step();
      @(negedge clk);
      chk("wrap_pc_fc",  {24'd0, instr_pc}, 32'hFC);
      chk("wrap_pc4_fc", {24'd0, instr_pc4}, 32'h00);
      step();
      @(negedge clk);
      chk("wrap_pc_00", {24'd0, instr_pc}, 32'h00);

      // Unaligned target is aligned down.
      step(); br = 1'b1; tgt = 8'h13;
      step(); br = 1'b0;
      @(negedge clk);
      chk("align_addr", {24'd0, imem_addr}, 32'h10);
      step(); step();
      @(negedge clk);
      chk("align_pc", {24'd0, instr_pc}, 32'h10);

      // Reset mid-run with the queue full, then restart from 0.
      step(); rdy = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step(); rst = 1'b0;
      @(negedge clk);
      check_zero("midrst");
      step(); start = 1'b1; rdy = 1'b1;
      step(); start = 1'b0;
      @(negedge clk);
      chk("restart_busy", {31'd0, busy}, 32'd1);
      chk("restart_addr", {24'd0, imem_addr}, 32'd0);
      chk("restart_en",   {31'd0, imem_en}, 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step();
         rst   = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 7) == 0);
         br    = ($urandom_range(0, 15) == 0);
         tgt   = 8'($urandom);
         rdy   = ($urandom_range(0, 3) != 0);
      end
      step();
      rst = 1'b0; start = 1'b0; br = 1'b0; rdy = 1'b1;
      repeat (5) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
